// File: rtl/gray_stream_decoder.sv
// Gray-code stream receiver: samples a Gray value on a strobe, decodes it to
// binary, tracks count direction and lock state, and counts illegal steps.
module gray_stream_decoder #(
  parameter int WIDTH       = 10,
  parameter int ERR_W       = 8,
  parameter int LOSS_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sample,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             dir_out,
  output logic             step_ok,
  output logic             locked,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

  state_t           state_q, state_d;
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             vld_q, vld_d;
  logic             dir_q, dir_d;
  logic             ok_q, ok_d;
  logic             lock_q, lock_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] delta;
  logic             acc;
  logic             is_up, is_dn, is_same;
  logic [3:0]       run_inc;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    new_bin = '0;
    acc     = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc        = acc ^ s1_gray_q[i];
      new_bin[i] = acc;
    end
  end

  assign delta   = new_bin - prev_q;
  assign is_up   = (delta == {{(WIDTH-1){1'b0}}, 1'b1});
  assign is_dn   = (delta == {WIDTH{1'b1}});
  assign is_same = (delta == '0);
  assign run_inc = run_q + 4'd1;

  // Handshake: a sample is accepted when en && sample; en=0 freezes both
  // stages, and out_valid pulses only on the cycle a stage-2 result lands.
  always_comb begin
    state_d   = state_q;
    s1_vld_d  = s1_vld_q;
    s1_gray_d = s1_gray_q;
    prev_d    = prev_q;
    run_d     = run_q;
    bin_d     = bin_q;
    vld_d     = 1'b0;
    dir_d     = dir_q;
    ok_d      = ok_q;
    lock_d    = lock_q;
    err_d     = err_q;

    if (en) begin
      s1_vld_d = sample;
      if (sample) begin
        s1_gray_d = gray_in;
      end
      if (s1_vld_q) begin
        vld_d  = 1'b1;
        bin_d  = new_bin;
        prev_d = new_bin;
        ok_d   = 1'b0;
        unique case (state_q)
          UNSYNC: state_d = ACQ;
          ACQ: begin
            if (is_up || is_dn) begin
              state_d = LOCKED;
              dir_d   = is_up;
              ok_d    = 1'b1;
            end
          end
          LOCKED: begin
            if (is_up || is_dn) begin
              dir_d = is_up;
              ok_d  = 1'b1;
              run_d = '0;
            end else if (is_same) begin
              ok_d  = 1'b1;
              run_d = '0;
            end else begin
              if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + 1'b1;
              end
              // A run of bad steps means the source is gone; drop lock.
              if (run_inc == THRESH) begin
                state_d = UNSYNC;
                run_d   = '0;
              end else begin
                run_d = run_inc;
              end
            end
          end
          default: state_d = UNSYNC;
        endcase
        lock_d = (state_d == LOCKED);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNSYNC;
      s1_vld_q  <= 1'b0;
      s1_gray_q <= '0;
      prev_q    <= '0;
      run_q     <= '0;
      bin_q     <= '0;
      vld_q     <= 1'b0;
      dir_q     <= 1'b1;
      ok_q      <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      s1_vld_q  <= s1_vld_d;
      s1_gray_q <= s1_gray_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      bin_q     <= bin_d;
      vld_q     <= vld_d;
      dir_q     <= dir_d;
      ok_q      <= ok_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = vld_q;
  assign dir_out   = dir_q;
  assign step_ok   = ok_q;
  assign locked    = lock_q;
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: a behavioural model pushes expected results
// into a queue at accept time; a monitor pops and compares each output pulse.
module tb_gray_stream_decoder;

  localparam int W  = 10;
  localparam int EW = 53;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         sample = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         out_valid;
  logic         dir_out;
  logic         step_ok;
  logic         locked;
  logic [7:0]   err_count;
  logic [1:0]   dbg_state;

  gray_stream_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sample    (sample),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .dir_out   (dir_out),
    .step_ok   (step_ok),
    .locked    (locked),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Entry layout: {due[52:21], bin[20:11], dir[10], ok[9], locked[8], err[7:0]}
  logic [EW-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;
  logic en_at_edge;
  logic [W-1:0] last_bin = '0;

  logic [W-1:0] m_prev;
  int           m_state;
  int           m_run;
  logic [7:0]   m_err;
  logic         m_dir;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = '0;
    m_state = 0;
    m_run   = 0;
    m_err   = '0;
    m_dir   = 1'b1;
  endtask

  task automatic model_accept(input logic [W-1:0] g, input int due);
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic [31:0]  due_v;
    logic         ok;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    d  = b - m_prev;
    ok = 1'b0;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (d == 10'd1) begin m_state = 2; m_dir = 1'b1; ok = 1'b1; end
        else if (d == 10'h3FF) begin m_state = 2; m_dir = 1'b0; ok = 1'b1; end
      end
      default: begin
        if (d == 10'd1) begin m_dir = 1'b1; ok = 1'b1; m_run = 0; end
        else if (d == 10'h3FF) begin m_dir = 1'b0; ok = 1'b1; m_run = 0; end
        else if (d == 10'd0) begin ok = 1'b1; m_run = 0; end
        else begin
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
          m_run++;
          if (m_run == 3) begin m_state = 0; m_run = 0; end
        end
      end
    endcase
    m_prev = b;
    due_v  = due;
    exp_q.push_back({due_v, b, m_dir, ok, (m_state == 2), m_err});
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [EW-1:0] e;
    en_at_edge = en;
    if (en) ecnt++;
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("latency",   ecnt,      e[52:21]);
        check_eq("bin_out",   bin_out,   e[20:11]);
        check_eq("dir_out",   dir_out,   e[10]);
        check_eq("step_ok",   step_ok,   e[9]);
        check_eq("locked",    locked,    e[8]);
        check_eq("err_count", err_count, e[7:0]);
        last_bin = e[20:11];
      end
    end else if (exp_q.size() != 0 && int'(exp_q[0][52:21]) <= ecnt) begin
      void'(exp_q.pop_front());
      check_eq("missing_valid", 32'd0, 32'd1);
    end
    if (!en_at_edge) begin
      check_eq("frozen_valid", out_valid, 32'd0);
      check_eq("frozen_bin",   bin_out,   last_bin);
    end
  end

  task automatic drive(input logic e, input logic s, input logic [W-1:0] g);
    @(negedge clk);
    en      = e;
    sample  = s;
    gray_in = g;
    if (e && s && !rst) model_accept(g, ecnt + 2);
  endtask

  task automatic send_bin(input logic [W-1:0] b);
    drive(1'b1, 1'b1, b ^ (b >> 1));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    en     = 1'b1;
    sample = 1'b0;
    exp_q.delete();
    model_reset();
    last_bin = '0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_bin",    bin_out,   32'd0);
    check_eq("rst_valid",  out_valid, 32'd0);
    check_eq("rst_dir",    dir_out,   32'd1);
    check_eq("rst_ok",     step_ok,   32'd0);
    check_eq("rst_locked", locked,    32'd0);
    check_eq("rst_err",    err_count, 32'd0);
    check_eq("rst_state",  dbg_state, 32'd0);
  endtask

  initial begin
    logic [W-1:0] rb;
    int sel;
    int k;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Basic decode and lock from gray 0,1,3,2
    drive(1'b1, 1'b1, 10'h000);
    drive(1'b1, 1'b1, 10'h001);
    drive(1'b1, 1'b1, 10'h003);
    drive(1'b1, 1'b1, 10'h002);
    idle(4);

    // Wrap up and wrap down
    do_reset();
    drive(1'b1, 1'b1, 10'h201);
    drive(1'b1, 1'b1, 10'h200);
    drive(1'b1, 1'b1, 10'h000);
    send_bin(10'd1);
    send_bin(10'd0);
    send_bin(10'd1023);
    idle(4);

    // Bad step, recovery, then loss of lock after three bad steps
    do_reset();
    send_bin(10'd4);
    send_bin(10'd5);
    drive(1'b1, 1'b1, 10'h00D);
    send_bin(10'd10);
    send_bin(10'd20);
    send_bin(10'd40);
    send_bin(10'd60);
    idle(4);
    check_eq("loss_locked", locked, 32'd0);
    check_eq("loss_err",    err_count, 32'd4);

    // Repeat then reversal
    do_reset();
    send_bin(10'd6);
    send_bin(10'd7);
    send_bin(10'd7);
    send_bin(10'd6);
    idle(4);

    // Enable freeze with an in-flight sample
    do_reset();
    send_bin(10'd100);
    send_bin(10'd101);
    send_bin(10'd102);
    repeat (5) drive(1'b0, 1'b1, 10'h155);
    send_bin(10'd103);
    idle(4);
    check_eq("freeze_err", err_count, 32'd0);

    // Random walk with occasional enable drops
    do_reset();
    rb = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 11);
      if (sel < 4) rb = rb + 10'd1;
      else if (sel < 7) rb = rb - 10'd1;
      else if (sel == 8) rb = 10'($urandom_range(0, 1023));
      if (sel == 11) drive(1'b0, 1'b1, rb ^ (rb >> 1));
      else if (sel == 10) drive(1'b1, 1'b0, '0);
      else send_bin(rb);
    end
    idle(4);

    // Reset one cycle after a strobe drops that sample, then relock
    send_bin(10'd300);
    do_reset();
    idle(3);
    send_bin(10'd50);
    send_bin(10'd51);
    idle(4);
    check_eq("relock", locked, 32'd1);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_stream_decoder.md
Name: gray_stream_decoder

Overview:
Receive-side counterpart to the LED Gray-code pattern generator. Samples a WIDTH-bit Gray value on a strobe and converts it back to binary. Infers count direction and checks that every step is a legal single-increment Gray transition. Sits between a pattern source (or board input pins) and the LED/7-seg display logic, and provides lock and error status for self-test.

Parameters:
WIDTH, 10, bit width of Gray input and binary output
ERR_W, 8, width of saturating error counter
LOSS_THRESH, 3, consecutive bad steps in LOCKED that force return to UNSYNC (range 1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  block enable; when 0, sample is ignored and all state holds
sample  input  1  one-cycle strobe; gray_in is valid in this cycle
gray_in  input  WIDTH  Gray-coded value
bin_out  output  WIDTH  decoded binary of last accepted sample
out_valid  output  1  one-cycle pulse when bin_out/step_ok/dir_out update
dir_out  output  1  1 = counting up, 0 = counting down (last legal step)
step_ok  output  1  1 = last step legal (±1 mod 2^WIDTH or repeat)
locked  output  1  1 while FSM is in LOCKED
err_count  output  ERR_W  saturating count of illegal steps while LOCKED

Behaviour:
- Reset (rst=1 at clk edge): bin_out=0, out_valid=0, dir_out=1, step_ok=0, locked=0, err_count=0. Internal previous-value register=0, bad-step run counter=0, FSM=UNSYNC. Reset overrides everything, including a sample in the same cycle.
- Accept condition: en && sample. Non-accepted cycles hold all registers; out_valid=0.
- Pipeline: stage 1 registers gray_in on accept. Stage 2 computes binary (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]) and registers it, then updates FSM and status. out_valid pulses, and bin_out/step_ok/dir_out/locked/err_count change, exactly 2 clk after the accept cycle. Back-to-back accepts are supported at full rate. en=0 freezes both stages, including an in-flight sample, which completes once en returns.
- delta = new_bin - prev_bin, modulo 2^WIDTH. UP means delta=1, DOWN means delta=all-ones, SAME means delta=0, and any other value is BAD. Wrap 2^WIDTH-1 -> 0 is UP. Wrap 0 -> 2^WIDTH-1 is DOWN.
- prev_bin always loads new_bin on every processed sample, in every state.
- FSM:
  - UNSYNC: first processed sample -> ACQ. step_ok=0.
  - ACQ: on UP or DOWN -> LOCKED, with dir_out set accordingly, step_ok=1. On SAME or BAD, stay in ACQ with step_ok=0. No err_count change in this state.
  - LOCKED, UP or DOWN: step_ok=1, dir_out set to the step direction (a reversal is legal), run counter cleared.
  - LOCKED, SAME: step_ok=1, dir_out held, run counter cleared.
  - LOCKED, BAD: step_ok=0, err_count += 1 (saturates at 2^ERR_W-1), run counter += 1. When the run counter reaches LOSS_THRESH: go to UNSYNC, locked=0, run counter cleared. err_count is retained.
- locked is a registered copy of (FSM==LOCKED) and updates with out_valid.
- err_count is cleared only by rst.

Test Plan:
- Reset, then gray_in 0x000,0x001,0x003,0x002 on consecutive strobes -> bin_out 0,1,2,3. Each out_valid arrives 2 clk after its strobe. locked=1 and dir_out=1 from the 2nd output. step_ok=0,1,1,1. err_count=0.
- Wrap up: lock on bin 1022,1023 (gray 0x201,0x200), then gray 0x000 -> bin_out=0, step_ok=1, dir_out=1. Wrap down from bin 1 to 0 to 1023 -> dir_out=0, step_ok=1, locked stays 1.
- Locked up-counting at bin 5, then gray for bin 9 (0x00D) -> step_ok=0, err_count=1, locked=1. Next bin 10 (legal from 9) -> step_ok=1, run counter cleared. Then 3 consecutive BAD steps -> err_count=4, locked=0 on the 3rd.
- Locked at bin 7, then bin 7 repeated, then bin 6 -> SAME gives step_ok=1 with dir held at 1. The reversal gives dir_out=0, step_ok=1.
- en=0 for 5 cycles with sample pulsing -> no out_valid, all outputs frozen. en=1 resumes with no spurious error.
- rst asserted 1 cycle after a strobe -> no out_valid for that sample. All outputs return to reset values and FSM=UNSYNC. The next 2 legal samples re-lock.
